test_multiply: RTL and testbench

- Self-checking hardware harness around a radix-2 (bit-serial) Montgomery modular multiplier.
- Generates pseudo-random 128-bit operand pairs on chip and computes MonPro(A,B) and MonPro(B,A) with one shared multiplier core.
- Compares the two results, pulses io_valid once per pair, and holds a sticky pass flag.
- Used as a standalone on-chip/simulation self-test of the Montgomery datapath.

---
 rtl/test_multiply_pkg.sv | 44 ++++
 rtl/test_multiply_core.sv | 96 +++++++++
 rtl/test_multiply.sv | 153 +++++++++++++++
 tb/tb_test_multiply.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/test_multiply_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_multiply_pkg
// Description : Shared constants, LFSR taps, FSM state encoding and small
//               helpers for the Montgomery multiplier self-test harness.
// Revision    : 1.0 - initial release
// ============================================================================
package test_multiply_pkg;

    // Operand / modulus width the LFSR polynomial is defined for
    localparam int WIDTH = 128;

    // Default modulus 2^128-1 and nonzero LFSR seeds
    localparam logic [WIDTH-1:0] M_DEF      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SEED_A_DEF = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [WIDTH-1:0] SEED_B_DEF = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

    // Feedback taps for x^128 + x^29 + x^27 + x^2 + 1
    localparam int LFSR_TAP0 = 127;
    localparam int LFSR_TAP1 = 28;
    localparam int LFSR_TAP2 = 26;
    localparam int LFSR_TAP3 = 1;

    // Harness sequencer states
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_MUL_AB = 2'd1,
        ST_MUL_BA = 2'd2,
        ST_CHECK  = 2'd3
    } state_e;

    // One Fibonacci step: shift left, feedback XOR enters at the LSB
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3]};
    endfunction

    // Single conditional subtraction; enough because the modulus is >= 2^(W-1)
    function automatic logic [WIDTH-1:0] reduce_once(input logic [WIDTH-1:0] v,
                                                     input logic [WIDTH-1:0] m);
        return (v >= m) ? (v - m) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_multiply_core.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_core
// Description : Radix-2 bit-serial Montgomery multiplier. Computes
//               X*Y*2^-W mod M in W+1 cycles after a start pulse; the last
//               cycle performs the final conditional subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_core
    import test_multiply_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic [W-1:0] M,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    logic [W+1:0]  s_q;
    logic [W+1:0]  s_d;
    logic [W-1:0]  x_q;
    logic [W-1:0]  y_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_d;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [W+1:0]  acc_in;
    logic [W+1:0]  sum_xy;
    logic [W+1:0]  sum_m;
    logic [W+1:0]  m_ext;
    logic          x_bit;
    logic [W-1:0]  y_op;

    // One Montgomery iteration; on start it runs on the fresh operands with S=0
    always_comb begin
        acc_in = start ? '0   : s_q;
        x_bit  = start ? X[0] : x_q[0];
        y_op   = start ? Y    : y_q;
        m_ext  = {2'b00, M};
        sum_xy = acc_in + (x_bit ? {2'b00, y_op} : '0);
        sum_m  = sum_xy + (sum_xy[0] ? m_ext : '0);
        s_d    = {1'b0, sum_m[W+1:1]};
    end

    // Final reduction: S < 2M after W iterations, so one subtraction suffices
    always_comb begin
        res_d = (s_q >= m_ext) ? W'(s_q - m_ext) : s_q[W-1:0];
    end

    // Iteration counter, accumulator and result register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                s_q    <= s_d;
                x_q    <= X >> 1;
                y_q    <= Y;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q == CNT_LAST) begin
                    res_q  <= res_d;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    s_q   <= s_d;
                    x_q   <= x_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign done   = done_q;
    assign result = res_q;

endmodule
`default_nettype wire

// File: rtl/test_multiply.sv
`default_nettype none
// ============================================================================
// Module      : test_multiply
// Description : Self-test harness: two LFSRs generate operand pairs, one
//               shared Montgomery core computes MonPro(A,B) and MonPro(B,A),
//               the results are compared and a sticky pass flag is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module test_multiply
    import test_multiply_pkg::*;
#(
    parameter int           W      = WIDTH,
    parameter logic [W-1:0] M      = M_DEF,
    parameter logic [W-1:0] SEED_A = SEED_A_DEF,
    parameter logic [W-1:0] SEED_B = SEED_B_DEF
) (
    input  logic         clock,
    input  logic         reset,
    output logic [W-1:0] io_A,
    output logic [W-1:0] io_B,
    output logic         io_valid,
    output logic         flag
);

    state_e       state_q;
    state_e       state_d;

    logic [W-1:0] lfsr_a_q;
    logic [W-1:0] lfsr_b_q;
    logic [W-1:0] r1_q;
    logic [W-1:0] r2_q;
    logic         flag_q;
    logic         flag_d;
    logic         fail_q;

    logic         core_start;
    logic [W-1:0] core_x;
    logic [W-1:0] core_y;
    logic         core_done;
    logic [W-1:0] core_result;
    logic         latch_r1;
    logic         latch_r2;
    logic         advance;

    // Operands presented to the core and the outside, reduced into [0, M)
    always_comb begin
        io_A = reduce_once(lfsr_a_q, M);
        io_B = reduce_once(lfsr_b_q, M);
    end

    montgomery_core #(
        .W (W)
    ) u_core (
        .clock  (clock),
        .reset  (reset),
        .start  (core_start),
        .X      (core_x),
        .Y      (core_y),
        .M      (M),
        .done   (core_done),
        .result (core_result)
    );

    // Sequencer state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state: each multiply phase ends on the core's done pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   state_d = ST_MUL_AB;
            ST_MUL_AB: if (core_done) state_d = ST_MUL_BA;
            ST_MUL_BA: if (core_done) state_d = ST_CHECK;
            ST_CHECK:  state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    // Sequencer outputs: core start/operand steering, result latches, valid
    always_comb begin
        core_start = 1'b0;
        core_x     = io_A;
        core_y     = io_B;
        latch_r1   = 1'b0;
        latch_r2   = 1'b0;
        advance    = 1'b0;
        io_valid   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                core_start = 1'b1;
            end
            ST_MUL_AB: begin
                // Second product reuses the core immediately with swapped operands
                core_x = io_B;
                core_y = io_A;
                if (core_done) begin
                    core_start = 1'b1;
                    latch_r1   = 1'b1;
                end
            end
            ST_MUL_BA: begin
                if (core_done) begin
                    latch_r2 = 1'b1;
                end
            end
            ST_CHECK: begin
                advance  = 1'b1;
                io_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Pass flag: a match only counts if no mismatch has ever been seen;
    // the CHECK cycle already shows the verdict for the pair being reported
    always_comb begin
        flag_d = (r1_q == r2_q) && !fail_q;
        flag   = advance ? flag_d : flag_q;
    end

    // Datapath registers: LFSRs, product latches, sticky pass/fail state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            r1_q     <= '0;
            r2_q     <= '0;
            flag_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            if (latch_r1) begin
                r1_q <= core_result;
            end
            if (latch_r2) begin
                r2_q <= core_result;
            end
            if (advance) begin
                lfsr_a_q <= lfsr_step(lfsr_a_q);
                lfsr_b_q <= lfsr_step(lfsr_b_q);
                flag_q   <= flag_d;
                fail_q   <= fail_q | (r1_q != r2_q);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_multiply.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_multiply
// Description : Directed self-checking bench for test_multiply and its
//               montgomery_core, with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_multiply;

    localparam logic [127:0] SEED_A  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] SEED_B  = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    // Seeds after one LFSR step (feedback bit is 0 for both)
    localparam logic [127:0] NEXT_A  = 128'h0246_8ACF_1357_9BDF_FDB9_7530_ECA8_6420;
    localparam logic [127:0] NEXT_B  = 128'h1E3C_5A78_96B4_D2F1_0F2D_4B69_87A5_C3E0;
    localparam logic [127:0] MOD     = {128{1'b1}};
    // Second instance: modulus 2^128-15 with seeds at/above it
    localparam logic [127:0] MOD2    = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1;
    localparam logic [127:0] R_NEXTB = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE3;

    logic         clock;
    logic         reset;
    logic [127:0] io_A;
    logic [127:0] io_B;
    logic         io_valid;
    logic         flag;

    logic [127:0] r_io_A;
    logic [127:0] r_io_B;
    logic         r_io_valid;
    logic         r_flag;

    logic         core_reset;
    logic         c_start;
    logic [127:0] c_x;
    logic [127:0] c_y;
    logic         c_done;
    logic [127:0] c_result;

    logic [127:0] fault_val;
    int           vectors;
    int           miscompares;
    int           edges;

    test_multiply dut (
        .clock    (clock),
        .reset    (reset),
        .io_A     (io_A),
        .io_B     (io_B),
        .io_valid (io_valid),
        .flag     (flag)
    );

    test_multiply #(
        .W      (128),
        .M      (MOD2),
        .SEED_A ({128{1'b1}}),
        .SEED_B (MOD2)
    ) dut_r (
        .clock    (clock),
        .reset    (reset),
        .io_A     (r_io_A),
        .io_B     (r_io_B),
        .io_valid (r_io_valid),
        .flag     (r_flag)
    );

    montgomery_core #(
        .W (128)
    ) u_core (
        .clock  (clock),
        .reset  (core_reset),
        .start  (c_start),
        .X      (c_x),
        .Y      (c_y),
        .M      (MOD),
        .done   (c_done),
        .result (c_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case a wait never resolves
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until io_valid is seen high (sampled on falling edge)
    task automatic wait_pulse(input int already, output int n);
        n = already;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end while (!io_valid && n < 600);
    endtask

    task automatic run_core(input string tag, input logic [127:0] x,
                            input logic [127:0] y, input logic [127:0] exp);
        int n;
        n = 0;
        @(negedge clock);
        c_x     = x;
        c_y     = y;
        c_start = 1'b1;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
            c_start = 1'b0;
        end while (!c_done && n < 300);
        check({tag, "_latency"}, 128'(n), 128'd129);
        check(tag, c_result, exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        core_reset  = 1'b0;
        c_start     = 1'b0;
        c_x         = '0;
        c_y         = '0;
        fault_val   = '0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_io_A",     io_A,            SEED_A);
        check("rst_io_B",     io_B,            SEED_B);
        check("rst_io_valid", 128'(io_valid),  128'd0);
        check("rst_flag",     128'(flag),      128'd0);
        check("rst_red_A",    r_io_A,          128'd14);
        check("rst_red_B",    r_io_B,          128'd0);

        // Core alone: with M = 2^128-1 the result is X*Y mod M
        core_reset = 1'b1;
        run_core("core_3x5",   128'd3,                 128'd5,  128'd15);
        run_core("core_2p127", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd2, 128'd1);
        run_core("core_zero",  128'd0,                 SEED_A,  128'd0);
        run_core("core_mm1",   MOD - 128'd1,           MOD - 128'd1, 128'd1);

        // Release harness reset; first pulse after 259 edges
        @(negedge clock);
        reset = 1'b1;
        wait_pulse(0, edges);
        check("pulse1_edges", 128'(edges), 128'd259);
        check("pulse1_flag",  128'(flag),  128'd1);
        check("pulse1_io_A",  io_A,        SEED_A);
        check("pulse1_rflag", 128'(r_flag), 128'd1);

        // Cycle after the pulse: pulse ended, operands advanced
        @(posedge clock);
        @(negedge clock);
        check("pulse1_width", 128'(io_valid), 128'd0);
        check("next_io_A",    io_A,           NEXT_A);
        check("next_io_B",    io_B,           NEXT_B);
        check("next_flag",    128'(flag),     128'd1);
        check("next_red_A",   r_io_A,         128'd13);
        check("next_red_B",   r_io_B,         R_NEXTB);

        wait_pulse(1, edges);
        check("pulse2_edges", 128'(edges), 128'd260);
        check("pulse2_flag",  128'(flag),  128'd1);

        // Pair 3: corrupt the second product by one bit during MUL_BA
        repeat (131) @(posedge clock);
        @(negedge clock);
        fault_val = dut.r1_q ^ 128'd1;
        force dut.core_result = fault_val;
        wait_pulse(131, edges);
        release dut.core_result;
        check("pulse3_edges", 128'(edges), 128'd260);
        check("pulse3_flag",  128'(flag),  128'd0);

        @(posedge clock);
        @(negedge clock);
        check("pulse3_width", 128'(io_valid), 128'd0);
        check("after3_flag",  128'(flag),     128'd0);

        wait_pulse(1, edges);
        check("pulse4_edges", 128'(edges), 128'd260);
        check("pulse4_sticky_flag", 128'(flag), 128'd0);

        // Fresh reset, then reset again in the middle of pair 2's MUL_AB
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        wait_pulse(0, edges);
        check("rr_pulse1_edges", 128'(edges), 128'd259);
        check("rr_pulse1_flag",  128'(flag),  128'd1);

        repeat (50) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_io_valid", 128'(io_valid), 128'd0);
        check("midrst_flag",     128'(flag),     128'd0);
        check("midrst_io_A",     io_A,           SEED_A);
        check("midrst_io_B",     io_B,           SEED_B);

        @(negedge clock);
        reset = 1'b1;
        wait_pulse(0, edges);
        check("midrst_pulse_edges", 128'(edges), 128'd259);
        check("midrst_pulse_flag",  128'(flag),  128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
